adder_traffic_gen: RTL and testbench
====================================

Name: adder_traffic_gen

Overview:
Synthesizable, parametrised packet stimulus generator for energy characterisation of an N-bit adder (or any two-operand datapath unit).
- Emits NUM_PACKETS packets of PAYLOAD flits, separated by GAP idle cycles. Each flit is W=2N bits, split into two operands.
- Flit content is selected per run by mode: thermometer-toggle, LFSR random, full-toggle or constant-zero.
- Uses a valid/ready handshake and keeps a running count of operand bit toggles, so switching activity is known on-chip.

Parameters:
- N, 12, operand width; W=2N must be 2..32.
- PAYLOAD, 20, flits per packet, >=1.
- GAP, 7, idle cycles after each packet, >=0.
- NUM_PACKETS, 10, packets per run, >=1.
- SEED, 32'h0000ACE1, LFSR load value, nonzero.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- mode  in  2  pattern select, sampled on accepted start
- out_ready  in  1  downstream accepts flit
- out_valid  out  1  flit presented
- operand_a  out  N  flit[N-1:0]
- operand_b  out  N  flit[W-1:N]
- sop  out  1  first flit of packet (qualified by out_valid)
- eop  out  1  last flit of packet (qualified by out_valid)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pkt_idx  out  $clog2(NUM_PACKETS+1)  current packet index
- toggle_count  out  32  saturating sum of flit bit toggles in the current run

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state IDLE, flit register 0, all outputs 0, LFSR=SEED. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 latches mode, loads LFSR=SEED, clears toggle_count, pkt_idx and beat s.
  - Loads the s=0 flit, then moves to SEND. out_valid is high in the following cycle (latency 1).
  - start while not IDLE is ignored. mode changes outside IDLE are ignored.
- SEND:
  - out_valid=1.
  - out_valid&out_ready accepts the flit. If s<PAYLOAD-1: s++ and load flit(s+1).
  - Accepting the last flit (s=PAYLOAD-1): pkt_idx++ and s=0.
    - Then go to DONE if pkt_idx+1==NUM_PACKETS.
    - Else go to GAP with a GAP-cycle countdown, or, if GAP==0, load flit(0) and stay in SEND (back-to-back packets).
  - out_ready=0: flit, s and counters hold; out_valid stays 1.
- GAP:
  - out_valid=0 and operands hold their last value (no spurious toggles).
  - After exactly GAP cycles, load flit(0) and enter SEND.
- DONE: done=1 for one cycle, busy=0, then IDLE. busy=1 in SEND and GAP.
- sop = (s==0); eop = (s==PAYLOAD-1).
- Flit register loads only at the points above. On every load, toggle_count += popcount(new^old), saturating at 2^32-1.
- Pattern flit(s), with ones(r) = W-bit value holding r low ones:
  - mode 0 (thermometer toggle): r = s mod W; s even -> ones(r), s odd -> ~ones(r). The pattern restarts at s=0 each packet.
  - mode 1 (random): flit = lfsr[W-1:0].
    - LFSR is 32-bit Galois, taps 32'h80200003; shift right, XOR taps when lsb=1.
    - It advances on each flit load after the first of the run and is not reset between packets.
  - mode 2 (full toggle): s even -> all ones, s odd -> all zeros.
  - mode 3 (constant): all zeros.

Decomposition:
- Package adder_traffic_pkg holds:
  - mode encoding: MODE_THERM=0, MODE_LFSR=1, MODE_TOGGLE=2, MODE_ZERO=3;
  - state enum;
  - LFSR_TAPS constant;
  - popcount function.
- One sub-module, lfsr32: load/advance enables, SEED parameter, 32-bit state output.

Test Plan:
- N=4, PAYLOAD=3, GAP=2, NUM_PACKETS=2, mode 2, out_ready=1, start at cycle 0:
  - flits FF,00,FF on cycles 1-3, idle cycles 4-5, FF,00,FF on cycles 6-8, done pulse at cycle 9;
  - toggle_count=40; sop on cycles 1 and 6, eop on cycles 3 and 8.
- Mode 0, N=4, PAYLOAD=5: flits 00,FE,03,F8,0F, i.e. operand_a 0,E,3,8,F and operand_b 0,F,0,F,0.
- Mode 1, N=12, PAYLOAD=2: first flit = 24'h00ACE1; second flit = Galois step of 32'h0000ACE1 = 32'h80205673, masked to 24'h205673.
- Backpressure: out_ready low 4 cycles mid-packet -> flit, sop/eop and toggle_count frozen, out_valid stays 1; completion is delayed by exactly 4 cycles.
- GAP=0 and start asserted while busy: packets run back-to-back with no valid bubble; the extra start has no effect.
- rst asserted in the middle of packet 1: the next cycle all outputs are 0, state is IDLE and no done pulse occurs. A fresh start then reproduces the scenario 1 sequence exactly.

Source files
------------

// File: rtl/adder_traffic_pkg.sv
// Shared types and helpers for the adder traffic generator: pattern modes,
// FSM states, LFSR taps and a popcount used for toggle accounting.
package adder_traffic_pkg;

  typedef enum logic [1:0] {
    MODE_THERM  = 2'd0,
    MODE_LFSR   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_ZERO   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load-to-seed and advance.
module lfsr32
  import adder_traffic_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000ACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] state_o,
  output logic [31:0] next_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    next_o  = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : '0);
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = next_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/adder_traffic_gen.sv
// Packetised operand stimulus generator for two-operand datapath energy
// characterisation, with valid/ready output and on-chip toggle counting.
module adder_traffic_gen
  import adder_traffic_pkg::*;
#(
  parameter int          N           = 12,
  parameter int          PAYLOAD     = 20,
  parameter int          GAP         = 7,
  parameter int          NUM_PACKETS = 10,
  parameter logic [31:0] SEED        = 32'h0000ACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [N-1:0]                       operand_a,
  output logic [N-1:0]                       operand_b,
  output logic                               sop,
  output logic                               eop,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_PACKETS+1)-1:0]   pkt_idx,
  output logic [31:0]                        toggle_count
);

  localparam int W  = 2 * N;
  localparam int BW = $clog2(PAYLOAD + 1);
  localparam int PW = $clog2(NUM_PACKETS + 1);
  localparam int GW = $clog2(GAP + 2);

  localparam logic [BW-1:0] LAST_BEAT = BW'(PAYLOAD - 1);
  localparam logic [PW-1:0] LAST_PKT  = PW'(NUM_PACKETS - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [W-1:0]    flit_q, flit_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [PW-1:0]   pkt_q, pkt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [31:0]     tog_q, tog_d;

  logic            load;
  logic [BW-1:0]   load_beat;
  logic            lfsr_load;
  logic            lfsr_adv;
  logic            tog_clear;

  logic [31:0]     lfsr_state;
  logic [31:0]     lfsr_next;
  logic            unused_lfsr;

  mode_e           pat_mode;
  logic [W-1:0]    rnd;
  logic [W-1:0]    ones;
  int unsigned     r;
  logic [W-1:0]    flit_new;
  logic [5:0]      pc;
  logic [32:0]     tog_sum;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  assign unused_lfsr = ^{lfsr_state, lfsr_next};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    gap_d     = gap_q;
    load      = 1'b0;
    load_beat = '0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    tog_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          beat_d    = '0;
          pkt_d     = '0;
          load      = 1'b1;
          lfsr_load = 1'b1;
          tog_clear = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (beat_q != LAST_BEAT) begin
            beat_d    = beat_q + 1'b1;
            load_beat = beat_q + 1'b1;
            load      = 1'b1;
            lfsr_adv  = 1'b1;
          end else begin
            beat_d = '0;
            pkt_d  = pkt_q + 1'b1;
            if (pkt_q == LAST_PKT) begin
              state_d = ST_DONE;
            end else if (GAP == 0) begin
              load     = 1'b1;
              lfsr_adv = 1'b1;
            end else begin
              gap_d   = GAP_INIT;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          load     = 1'b1;
          lfsr_adv = 1'b1;
          state_d  = ST_SEND;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The first flit of a run is built from the incoming mode and the seed,
  // since neither register holds them yet; later loads use the LFSR look-ahead.
  always_comb begin
    pat_mode = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;
    rnd      = (state_q == ST_IDLE) ? SEED[W-1:0] : lfsr_next[W-1:0];
    r        = 32'(load_beat) % 32'(W);
    for (int unsigned i = 0; i < W; i++) begin
      ones[i] = (i < r);
    end
    case (pat_mode)
      MODE_THERM:  flit_new = load_beat[0] ? ~ones : ones;
      MODE_LFSR:   flit_new = rnd;
      MODE_TOGGLE: flit_new = load_beat[0] ? '0 : '1;
      default:     flit_new = '0;
    endcase
  end

  always_comb begin
    pc      = popcount(32'(flit_new ^ flit_q));
    tog_sum = {1'b0, (tog_clear ? 32'd0 : tog_q)} + 33'(pc);
    flit_d  = flit_q;
    tog_d   = tog_q;
    if (load) begin
      flit_d = flit_new;
      tog_d  = tog_sum[32] ? '1 : tog_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_THERM;
      flit_q  <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      flit_q  <= flit_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      tog_q   <= tog_d;
    end
  end

  assign out_valid    = (state_q == ST_SEND);
  assign busy         = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);
  assign sop          = out_valid && (beat_q == '0);
  assign eop          = out_valid && (beat_q == LAST_BEAT);
  assign operand_a    = flit_q[N-1:0];
  assign operand_b    = flit_q[W-1:N];
  assign pkt_idx      = pkt_q;
  assign toggle_count = tog_q;

endmodule

// File: tb/tb_adder_traffic_gen.sv
// Scoreboard bench for adder_traffic_gen: two instances (gapped and
// back-to-back), expected flits queued at start and checked as they appear.
module tb_adder_traffic_gen;

  localparam int NA = 4,  PA = 3, GA = 2, NPA = 2;
  localparam int NB = 12, PB = 5, GB = 0, NPB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sA, rA, vA, sopA, eopA, busyA, doneA;
  logic [1:0]    mA, pkA;
  logic [NA-1:0] aA, bA;
  logic [31:0]   tgA;

  logic          sB, rB, vB, sopB, eopB, busyB, doneB;
  logic [1:0]    mB, pkB;
  logic [NB-1:0] aB, bB;
  logic [31:0]   tgB;

  adder_traffic_gen #(.N(NA), .PAYLOAD(PA), .GAP(GA), .NUM_PACKETS(NPA), .SEED(32'h0000ACE1)) u_dut_a (
    .clk(clk), .rst(rst), .start(sA), .mode(mA), .out_ready(rA), .out_valid(vA),
    .operand_a(aA), .operand_b(bA), .sop(sopA), .eop(eopA), .busy(busyA), .done(doneA),
    .pkt_idx(pkA), .toggle_count(tgA)
  );

  adder_traffic_gen #(.N(NB), .PAYLOAD(PB), .GAP(GB), .NUM_PACKETS(NPB), .SEED(32'h0000ACE1)) u_dut_b (
    .clk(clk), .rst(rst), .start(sB), .mode(mB), .out_ready(rB), .out_valid(vB),
    .operand_a(aB), .operand_b(bB), .sop(sopB), .eop(eopB), .busy(busyB), .done(doneB),
    .pkt_idx(pkB), .toggle_count(tgB)
  );

  typedef struct {
    logic [31:0] flit;
    logic        sop;
    logic        eop;
    logic [31:0] pkt;
    logic [31:0] tog;
    int unsigned idle;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned run_cyc[2];
  int unsigned idle_cnt[2];
  int unsigned exp_len[2];
  logic [31:0] exp_tog[2];
  logic [31:0] prev_flit[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
  endfunction

  function automatic logic [31:0] pattern(input int md, input int w, input int s, input logic [31:0] l);
    logic [63:0] ones;
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    ones = (64'd1 << (s % w)) - 64'd1;
    case (md)
      0:       return (s % 2 == 0) ? ones[31:0] : (~ones[31:0] & mask);
      1:       return l & mask;
      2:       return (s % 2 == 0) ? mask : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic gen_run(input int k, input int md, input int w, input int p, input int g,
                         input int np, input int stall);
    logic [31:0] l, f, t;
    exp_t e;
    l = 32'h0000ACE1;
    t = 32'd0;
    for (int pk = 0; pk < np; pk++) begin
      for (int s = 0; s < p; s++) begin
        if (!(pk == 0 && s == 0)) l = lfsr_adv(l);
        f = pattern(md, w, s, l);
        t = t + 32'($countones(f ^ prev_flit[k]));
        prev_flit[k] = f;
        e.flit = f;
        e.sop  = (s == 0);
        e.eop  = (s == p - 1);
        e.pkt  = 32'(pk);
        e.tog  = t;
        e.idle = (pk > 0 && s == 0) ? g : 0;
        if (k == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    exp_len[k] = np * p + (np - 1) * g + 1 + stall;
    exp_tog[k] = t;
  endtask

  task automatic mon(input int k, input logic valid, input logic ready, input logic [31:0] flit,
                     input logic so, input logic eo, input logic [31:0] pkt, input logic [31:0] tog,
                     input logic strt, input logic bsy, input logic dn);
    exp_t  e;
    string sx;
    int    qs;
    sx = (k == 0) ? "_a" : "_b";
    qs = (k == 0) ? qa.size() : qb.size();
    if (strt && !bsy && !dn) begin
      run_cyc[k]  = 0;
      idle_cnt[k] = 0;
    end else if (bsy || dn) begin
      run_cyc[k]++;
    end
    if (valid) begin
      if (qs == 0) begin
        chk({"unexp_valid", sx}, 32'(valid), 32'd0);
      end else begin
        e = (k == 0) ? qa[0] : qb[0];
        chk({"flit", sx}, flit, e.flit);
        chk({"sop", sx}, 32'(so), 32'(e.sop));
        chk({"eop", sx}, 32'(eo), 32'(e.eop));
        chk({"pkt", sx}, pkt, e.pkt);
        chk({"tog", sx}, tog, e.tog);
        chk({"idle_before", sx}, idle_cnt[k], e.idle);
        if (ready) begin
          if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
          idle_cnt[k] = 0;
        end
      end
    end else if (bsy) begin
      idle_cnt[k]++;
    end
    if (dn) begin
      chk({"done_pending", sx}, 32'(qs), 32'd0);
      chk({"done_len", sx}, run_cyc[k], exp_len[k]);
      chk({"done_tog", sx}, tog, exp_tog[k]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, vA, rA, 32'({bA, aA}), sopA, eopA, 32'(pkA), tgA, sA, busyA, doneA);
      mon(1, vB, rB, 32'({bB, aB}), sopB, eopB, 32'(pkB), tgB, sB, busyB, doneB);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int k, input int md, input int stall);
    if (k == 0) begin
      mA = 2'(md); sA = 1'b1;
      gen_run(0, md, 2 * NA, PA, GA, NPA, stall);
    end else begin
      mB = 2'(md); sB = 1'b1;
      gen_run(1, md, 2 * NB, PB, GB, NPB, stall);
    end
    tick(1);
    sA = 1'b0;
    sB = 1'b0;
  endtask

  task automatic wait_done(input int k);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((k == 0) ? doneA : doneB) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    if (!seen) chk((k == 0) ? "done_timeout_a" : "done_timeout_b", 32'((k == 0) ? doneA : doneB), 32'd1);
    tick(1);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_valid"}, 32'(vA), 32'd0);
    chk({tag, "_busy"},  32'(busyA), 32'd0);
    chk({tag, "_done"},  32'(doneA), 32'd0);
    chk({tag, "_sop"},   32'(sopA), 32'd0);
    chk({tag, "_eop"},   32'(eopA), 32'd0);
    chk({tag, "_flit"},  32'({bA, aA}), 32'd0);
    chk({tag, "_pkt"},   32'(pkA), 32'd0);
    chk({tag, "_tog"},   tgA, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sA = 1'b0; mA = 2'd0; rA = 1'b1;
    sB = 1'b0; mB = 2'd0; rB = 1'b1;
    prev_flit[0] = '0; prev_flit[1] = '0;
    exp_len[0] = 0;    exp_len[1] = 0;
    exp_tog[0] = '0;   exp_tog[1] = '0;
    run_cyc[0] = 0;    run_cyc[1] = 0;
    idle_cnt[0] = 0;   idle_cnt[1] = 0;
    tick(2);
    rst = 1'b0;

    chk_zero_a("reset");
    chk("reset_valid_b", 32'(vB), 32'd0);
    chk("reset_flit_b", 32'({bB, aB}), 32'd0);

    // Full toggle, two gapped packets
    start_run(0, 2, 0);
    wait_done(0);
    chk("s1_tog_a", tgA, 32'd40);
    chk("s1_pkt_a", 32'(pkA), 32'd2);

    start_run(0, 0, 0);
    wait_done(0);
    start_run(0, 3, 0);
    wait_done(0);

    // Four-cycle stall on the second beat of the first packet
    start_run(0, 2, 4);
    tick(1);
    rA = 1'b0;
    tick(4);
    rA = 1'b1;
    wait_done(0);

    // Abort during packet 1, then rerun
    start_run(0, 2, 0);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    qa.delete();
    exp_len[0] = 0;
    prev_flit[0] = '0;
    chk_zero_a("abort");
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done_a", 32'(doneA), 32'd0);
      tick(1);
    end
    start_run(0, 2, 0);
    wait_done(0);
    chk("rerun_tog_a", tgA, 32'd40);

    // LFSR anchors on the 24-bit instance
    start_run(1, 1, 0);
    chk("lfsr_f0_b", 32'({bB, aB}), 32'h00ACE1);
    tick(1);
    chk("lfsr_f1_b", 32'({bB, aB}), 32'h205673);
    wait_done(1);

    start_run(1, 0, 0);
    wait_done(1);

    // Back-to-back packets with a stray start mid-run
    start_run(1, 2, 0);
    tick(3);
    mB = 2'd3;
    sB = 1'b1;
    tick(1);
    sB = 1'b0;
    wait_done(1);
    tick(2);
    chk("stray_start_busy_b", 32'(busyB), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
